// File: rtl/seq_arbiter.sv
// Round-robin owner of a shared setup/active/done resource; drives ctl for a per-requester active length.
// Grant one edge after a request; ctl for max(len,1) cycles; one-cycle ack; all outputs decode from flops only.
module seq_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic                  abort,
  output logic [NREQ-1:0]       gnt,
  output logic                  ctl,
  output logic [NREQ-1:0]       ack,
  output logic                  busy
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, GO, DONE} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  owner_oh;
  logic [NREQ-1:0]  cand;
  logic [OW-1:0]    owner_inc;
  logic [OW-1:0]    start;
  logic [OW-1:0]    idx;
  logic [OW-1:0]    win;
  logic             found;
  logic [LEN_W-1:0] win_len;
  logic [LEN_W-1:0] win_cnt;

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
    if (v == OW'(NREQ - 1)) return '0;
    return v + OW'(1);
  endfunction

  assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign owner_inc = wrap_inc(owner_q);

  // In DONE the finishing owner is masked and the search starts just past it.
  assign start = (state_q == DONE) ? owner_inc : ptr_q;
  assign cand  = req & ~((state_q == DONE) ? owner_oh : '0);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = start;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  assign win_len = len[win*LEN_W +: LEN_W];
  assign win_cnt = (win_len == '0) ? '0 : win_len - LEN_W'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = win;
          cnt_d   = win_cnt;
        end
      end
      GRANT: state_d = GO;
      GO: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - LEN_W'(1);
      end
      DONE: begin
        ptr_d = owner_inc;
        if (found) begin
          state_d = GRANT;
          owner_d = win;
          cnt_d   = win_cnt;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort drops the job without ack but still moves fairness past the owner.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      ptr_d   = owner_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign gnt  = busy ? owner_oh : '0;
  assign ctl  = (state_q == GO);
  assign ack  = (state_q == DONE) ? owner_oh : '0;

endmodule

// File: tb/tb_seq_arbiter.sv
// Directed vector bench for seq_arbiter (NREQ=4, LEN_W=4): table of per-cycle vectors plus an async-reset sequence.
module tb_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic [3:0]  gnt;
  logic        ctl;
  logic [3:0]  ack;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  seq_arbiter #(.NREQ(4), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len   (len),
    .abort (abort),
    .gnt   (gnt),
    .ctl   (ctl),
    .ack   (ack),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tst;
    logic        rs;
    logic [3:0]  r;
    logic [15:0] l;
    logic        a;
    logic [3:0]  eg;
    logic        ec;
    logic [3:0]  ea;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int t, input logic rs, input logic [3:0] r, input logic [15:0] l,
                     input logic a, input logic [3:0] eg, input logic ec, input logic [3:0] ea,
                     input logic eb);
    vec_t v;
    v.tst = t; v.rs = rs; v.r = r; v.l = l; v.a = a;
    v.eg = eg; v.ec = ec; v.ea = ea; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic ec,
                     input logic [3:0] ea, input logic eb);
    n_vec++;
    if (gnt !== eg || ctl !== ec || ack !== ea || busy !== eb) begin
      n_err++;
      $display("FAIL %s: got gnt=%b ctl=%b ack=%b busy=%b, want gnt=%b ctl=%b ack=%b busy=%b",
               nm, gnt, ctl, ack, busy, eg, ec, ea, eb);
    end
  endtask

  task automatic step(input logic rs, input logic [3:0] r, input logic [15:0] l, input logic a);
    @(negedge clk);
    rst_n = rs; req = r; len = l; abort = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // t1: reset, then single request 0 with len 3
    add(1, 0, 4'b0000, 16'h0003, 0, 4'b0000, 0, 4'b0000, 0);
    add(1, 1, 4'b0001, 16'h0003, 0, 4'b0001, 0, 4'b0000, 1);
    add(1, 1, 4'b0001, 16'h0003, 0, 4'b0001, 1, 4'b0000, 1);
    add(1, 1, 4'b0001, 16'h0003, 0, 4'b0001, 1, 4'b0000, 1);
    add(1, 1, 4'b0001, 16'h0003, 0, 4'b0001, 1, 4'b0000, 1);
    add(1, 1, 4'b0001, 16'h0003, 0, 4'b0001, 0, 4'b0001, 1);
    add(1, 1, 4'b0000, 16'h0003, 0, 4'b0000, 0, 4'b0000, 0);
    // t2: len 0 on requester 2 runs ctl for one cycle
    add(2, 1, 4'b0100, 16'h0000, 0, 4'b0100, 0, 4'b0000, 1);
    add(2, 1, 4'b0100, 16'h0000, 0, 4'b0100, 1, 4'b0000, 1);
    add(2, 1, 4'b0100, 16'h0000, 0, 4'b0100, 0, 4'b0100, 1);
    add(2, 1, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'b0000, 0);
    // t3: all four requesting from reset, len 1, back-to-back with no idle gap
    add(3, 0, 4'b0000, 16'h1111, 0, 4'b0000, 0, 4'b0000, 0);
    add(3, 1, 4'b1111, 16'h1111, 0, 4'b0001, 0, 4'b0000, 1);
    add(3, 1, 4'b1111, 16'h1111, 0, 4'b0001, 1, 4'b0000, 1);
    add(3, 1, 4'b1111, 16'h1111, 0, 4'b0001, 0, 4'b0001, 1);
    add(3, 1, 4'b1110, 16'h1111, 0, 4'b0010, 0, 4'b0000, 1);
    add(3, 1, 4'b1110, 16'h1111, 0, 4'b0010, 1, 4'b0000, 1);
    add(3, 1, 4'b1110, 16'h1111, 0, 4'b0010, 0, 4'b0010, 1);
    add(3, 1, 4'b1100, 16'h1111, 0, 4'b0100, 0, 4'b0000, 1);
    add(3, 1, 4'b1100, 16'h1111, 0, 4'b0100, 1, 4'b0000, 1);
    add(3, 1, 4'b1100, 16'h1111, 0, 4'b0100, 0, 4'b0100, 1);
    add(3, 1, 4'b1000, 16'h1111, 0, 4'b1000, 0, 4'b0000, 1);
    add(3, 1, 4'b1000, 16'h1111, 0, 4'b1000, 1, 4'b0000, 1);
    add(3, 1, 4'b1000, 16'h1111, 0, 4'b1000, 0, 4'b1000, 1);
    add(3, 1, 4'b0000, 16'h1111, 0, 4'b0000, 0, 4'b0000, 0);
    // t4: fairness, req0 held, req3 joins; 3 must win after 0's ack
    add(4, 1, 4'b0001, 16'h1111, 0, 4'b0001, 0, 4'b0000, 1);
    add(4, 1, 4'b0001, 16'h1111, 0, 4'b0001, 1, 4'b0000, 1);
    add(4, 1, 4'b1001, 16'h1111, 0, 4'b0001, 0, 4'b0001, 1);
    add(4, 1, 4'b1001, 16'h1111, 0, 4'b1000, 0, 4'b0000, 1);
    add(4, 1, 4'b1001, 16'h1111, 0, 4'b1000, 1, 4'b0000, 1);
    add(4, 1, 4'b1001, 16'h1111, 0, 4'b1000, 0, 4'b1000, 1);
    add(4, 1, 4'b0001, 16'h1111, 0, 4'b0001, 0, 4'b0000, 1);
    add(4, 1, 4'b0001, 16'h1111, 0, 4'b0001, 1, 4'b0000, 1);
    add(4, 1, 4'b0001, 16'h1111, 0, 4'b0001, 0, 4'b0001, 1);
    add(4, 1, 4'b0000, 16'h1111, 0, 4'b0000, 0, 4'b0000, 0);
    // t5: abort in 2nd GO cycle of requester 1 (len 4); ptr then wraps to 0
    add(5, 1, 4'b0011, 16'h0041, 0, 4'b0010, 0, 4'b0000, 1);
    add(5, 1, 4'b0011, 16'h0041, 0, 4'b0010, 1, 4'b0000, 1);
    add(5, 1, 4'b0011, 16'h0041, 0, 4'b0010, 1, 4'b0000, 1);
    add(5, 1, 4'b0011, 16'h0041, 1, 4'b0000, 0, 4'b0000, 0);
    add(5, 1, 4'b0011, 16'h0041, 0, 4'b0001, 0, 4'b0000, 1);
    add(5, 1, 4'b0011, 16'h0041, 0, 4'b0001, 1, 4'b0000, 1);
    add(5, 1, 4'b0011, 16'h0041, 0, 4'b0001, 0, 4'b0001, 1);
    add(5, 1, 4'b0000, 16'h0041, 0, 4'b0000, 0, 4'b0000, 0);
    // t5b: abort while idle changes nothing
    add(5, 1, 4'b0000, 16'h0041, 1, 4'b0000, 0, 4'b0000, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rs, tbl[i].r, tbl[i].l, tbl[i].a);
      chk($sformatf("t%0d_vec%0d", tbl[i].tst, i), tbl[i].eg, tbl[i].ec, tbl[i].ea, tbl[i].eb);
    end

    // t6: async reset mid-GO, then requester 3 gets a full job
    step(1, 4'b0001, 16'h0005, 0);
    chk("t6_grant0", 4'b0001, 0, 4'b0000, 1);
    step(1, 4'b0001, 16'h0005, 0);
    step(1, 4'b0001, 16'h0005, 0);
    chk("t6_in_go", 4'b0001, 1, 4'b0000, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_immediate", 4'b0000, 0, 4'b0000, 0);
    @(posedge clk);
    #1;
    chk("t6_rst_held", 4'b0000, 0, 4'b0000, 0);
    step(1, 4'b1000, 16'h3005, 0);
    chk("t6_grant3", 4'b1000, 0, 4'b0000, 1);
    begin
      int  ctl_cnt;
      bit  got;
      ctl_cnt = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(posedge clk);
        #1;
        if (ack != 4'b0000) got = 1'b1;
        else if (ctl) ctl_cnt++;
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL t6_ack_timeout: no ack within 20 cycles, want ack=1000");
      end else if (ack !== 4'b1000 || ctl_cnt != 3) begin
        n_err++;
        $display("FAIL t6_full_len: got ack=%b ctl_cycles=%0d, want ack=1000 ctl_cycles=3", ack, ctl_cnt);
      end
    end
    step(1, 4'b0000, 16'h3005, 0);
    chk("t6_idle", 4'b0000, 0, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
